// File: rtl/led_refresh_ctrl.sv
// led_refresh_ctrl: activity-LED stretcher with global PWM dimming and a
// continuous serial refresh of an external 8-bit 74HC595-style shift register.
// The static status input is named force_lvl because "force" is a reserved word.
module led_refresh_ctrl #(
    parameter int unsigned CLK_DIV    = 28000,
    parameter int unsigned HOLD_TICKS = 50,
    parameter int unsigned SCLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] act,
    input  logic [7:0] force_lvl,
    input  logic [3:0] bright,
    output logic [7:0] led_state,
    output logic       led_sclk,
    output logic       led_sdo,
    output logic       led_latch,
    output logic       busy
);

    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
    localparam int unsigned DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [HW-1:0] hold [8];
    logic [7:0]    hold_nz;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic [3:0]    pwm_cnt, pwm_n;
    logic          sclk_n, sdo_n, latch_n;
    logic          div_last;
    logic          pwm_on;
    logic [7:0]    frame_data;

    assign tick       = (pre_cnt == PRE_LAST);
    assign div_last   = (div_cnt == DIV_LAST);
    assign pwm_on     = (bright == 4'hF) || (pwm_cnt < bright);
    assign frame_data = led_state & {8{pwm_on}};

    // Hold-tick prescaler, wraps at CLK_DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Per-channel hold counters; a strobe reload takes priority over a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (act[i]) begin
                    hold[i] <= HOLD_LOAD;
                end else if (tick && (hold[i] != '0)) begin
                    hold[i] <= hold[i] - HW'(1);
                end
            end
        end
    end

    // Nonzero flags of the hold counters.
    always_comb begin
        hold_nz = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            hold_nz[i] = (hold[i] != '0);
        end
    end

    // Stretched, undimmed LED vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_state <= '0;
        end else begin
            led_state <= act | hold_nz | force_lvl;
        end
    end

    // Refresh FSM next-state; pin values are computed for the next state so the
    // serial pins come straight from flops and change on state entry only.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        pwm_n   = pwm_cnt;
        sclk_n  = led_sclk;
        sdo_n   = led_sdo;
        latch_n = led_latch;
        case (state)
            IDLE: begin
                sclk_n  = 1'b0;
                latch_n = 1'b0;
                if (en) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                shreg_n = frame_data;
                bit_n   = 3'd7;
                div_n   = '0;
                sdo_n   = frame_data[7];
                sclk_n  = 1'b0;
                latch_n = 1'b0;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_n   = '0;
                    sclk_n  = 1'b1;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_n  = '0;
                    sclk_n = 1'b0;
                    if (bit_cnt == 3'd0) begin
                        latch_n = 1'b1;
                        sdo_n   = 1'b0;
                        state_n = LATCH;
                    end else begin
                        bit_n   = bit_cnt - 3'd1;
                        sdo_n   = shreg[bit_cnt - 3'd1];
                        state_n = SHIFT_LO;
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_n   = '0;
                    latch_n = 1'b0;
                    pwm_n   = pwm_cnt + 4'd1;
                    state_n = en ? LOAD : IDLE;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                sclk_n  = 1'b0;
                sdo_n   = 1'b0;
                latch_n = 1'b0;
            end
        endcase
    end

    // Refresh FSM state, datapath and registered serial pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pwm_cnt   <= '0;
            led_sclk  <= 1'b0;
            led_sdo   <= 1'b0;
            led_latch <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            pwm_cnt   <= pwm_n;
            led_sclk  <= sclk_n;
            led_sdo   <= sdo_n;
            led_latch <= latch_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule
